hsv_core_alu_exec: RTL and testbench
====================================

// Module: hsv_core_alu_exec
// PURPOSE
//  Execute stage directly downstream of the ALU opcode decoder. Consumes alu_data_t
//  plus operand values from issue, computes add/sub/compare/bitwise/shift in a 2-stage
//  valid/ready pipeline, and hands result + exec_mem_common_t to the commit/writeback arbiter.
// PARAMETERS
//  XLEN     32             datapath width; only 32 supported (elaboration $error otherwise)
//  SHAMT_W  $clog2(XLEN)   shift-amount width (5)
// PORTS
//  clk_core     in   1                  core clock
//  rst_core     in   1                  synchronous, active-high reset
//  flush_req    in   1                  pipeline flush (trap/mispredict)
//  in_valid     in   1                  upstream has a decoded ALU op
//  in_ready     out  1                  stage can accept this cycle
//  in_alu_data  in   $bits(alu_data_t)  decoded control (negate, flip_signs, bitwise_select, ...)
//  in_rs1       in   XLEN               rs1 value (issue drives 0 for LUI)
//  in_rs2       in   XLEN               rs2 value
//  in_imm       in   XLEN               sign-extended immediate
//  in_pc        in   XLEN               instruction PC
//  out_valid    out  1                  result available
//  out_ready    in   1                  downstream accepts
//  out_result   out  XLEN               ALU result
//  out_common   out  $bits(exec_mem_common_t)  passthrough of in_alu_data.common
//  out_illegal  out  1                  passthrough of in_alu_data.illegal
// BEHAVIOUR
//  - Reset: s1_valid=s2_valid=0, out_valid=0, out_result=0, out_illegal=0, in_ready=1 next cycle.
//  - Handshake: transfer on valid&&ready; in_ready = !s1_valid || (s1 advancing);
//    s1 advances when !s2_valid || (out_valid&&out_ready). No bubbles under full flow.
//  - Latency: accept in cycle N -> out_valid in N+2; throughput 1 op/cycle; order preserved.
//  - S1 (setup, registered): a = pc_relative ? in_pc : in_rs1; b = is_immediate ? in_imm : in_rs2;
//    if flip_signs invert a[31], b[31]; latch control + common.
//  - S2 (compute, registered):
//    adder: sum = a + (negate ? ~b : b) + negate, 33-bit carry kept.
//    compare=1: result = {31'b0, ~carry} (a<b unsigned after sign flip).
//    out_select ADDER -> sum/compare; SHIFT -> bitwise_select AND/OR/XOR = a op b,
//    PASS -> shift by b[SHAMT_W-1:0]: right logical; sign_extend -> arithmetic;
//    negate -> left shift (bit-reverse a, shift right, bit-reverse result). shamt 0 -> a.
//  - illegal=1: op flows normally, out_result forced 0, out_illegal=1.
//  - Stall: out_valid high & !out_ready -> out_* held stable, no S2 overwrite.
//  - Flush: flush_req clears s1_valid, s2_valid next edge; in_valid in the flush cycle is dropped
//    (in_ready still reported, no transfer). Flush wins over simultaneous accept/advance.
//  - Reset mid-op: in-flight ops discarded, no out_valid until new accept.
// CONFIGURATION
//  HSV_ALU_OUT_SKID_EN defined: 2-entry skid buffer after S2; in_ready/S1 advance depend
//    only on registered state (no comb out_ready->in_ready path); latency unchanged
//    when unstalled; flush clears skid entries too.
//  Undefined: out_* driven straight from S2; out_ready combinationally gates advance.
// STRUCTURE
//  - hsv_core_pkg: alu_setup_t (a, b, control, common, illegal), ALU_SHAMT_W; reuses
//    alu_data_t, alu_out_select/alu_bitwise enums, exec_mem_common_t, word.
//  - Sub-module hsv_core_alu_skid (generic 2-entry valid/ready skid, used only under macro).
//  - Shifter, adder: inline always_comb in S2.
// TESTING
//  1 ADD rs1=5 rs2=7 -> out_result=12, out_valid 2 cycles after accept.
//  2 SLT rs1=0xFFFF_FFFF rs2=1 -> 1; SLTU same operands -> 0; SUB 3-5 -> 0xFFFF_FFFE.
//  3 SLL a=1 b=31 -> 0x8000_0000; SRA a=0x8000_0000 b=4 -> 0xF800_0000; SRL same -> 0x0800_0000.
//  4 AUIPC pc=0x1000 imm=0x2000 -> 0x3000; illegal=1 ADD -> result 0, out_illegal=1.
//  5 Back-to-back 8 ops with out_ready low 3 cycles mid-stream -> all 8 in order, outputs stable.
//  6 flush_req with 2 ops in flight + in_valid same cycle -> none emerge; next op after is correct.

Source files
------------

// File: rtl/hsv_core_pkg.sv
// Shared types for the ALU execute stage: decoded control, setup register, helpers.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package hsv_core_pkg;

    typedef logic [31:0] word;

    localparam int ALU_SHAMT_W = 5;

    typedef enum logic {
        ALU_OUT_ADDER = 1'b0,
        ALU_OUT_SHIFT = 1'b1
    } alu_out_select_t;

    // PASS routes the shifter; the others are plain a op b.
    typedef enum logic [1:0] {
        ALU_BITWISE_AND  = 2'd0,
        ALU_BITWISE_OR   = 2'd1,
        ALU_BITWISE_XOR  = 2'd2,
        ALU_BITWISE_PASS = 2'd3
    } alu_bitwise_t;

    typedef struct packed {
        logic [4:0] rd;
        logic [3:0] tag;
    } exec_mem_common_t;

    typedef struct packed {
        alu_out_select_t  out_select;
        alu_bitwise_t     bitwise_select;
        logic             negate;
        logic             flip_signs;
        logic             compare;
        logic             sign_extend;
        logic             pc_relative;
        logic             is_immediate;
        logic             illegal;
        exec_mem_common_t common;
    } alu_data_t;

    typedef struct packed {
        alu_out_select_t out_select;
        alu_bitwise_t    bitwise_select;
        logic            negate;
        logic            compare;
        logic            sign_extend;
    } alu_ctrl_t;

    typedef struct packed {
        word              a;
        word              b;
        alu_ctrl_t        control;
        exec_mem_common_t common;
        logic             illegal;
    } alu_setup_t;

    function automatic word bit_reverse(input word v);
        word r;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/hsv_core_alu_skid.sv
// Generic 2-entry valid/ready skid buffer with empty-bypass and registered o_rdy.
// Latency: 0 cycles when empty (combinational bypass), otherwise FIFO order.
// Backpressure: o_rdy drops only when both entries are full; flush empties it.
module hsv_core_alu_skid #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_flush,
    input  logic         i_vld,
    input  logic [W-1:0] i_dat,
    output logic         o_rdy,
    output logic         o_vld,
    output logic [W-1:0] o_dat,
    input  logic         i_rdy
);

    logic [1:0]   r_cnt;
    logic [W-1:0] r_d0;
    logic [W-1:0] r_d1;
    logic         w_push;
    logic         w_pop;

    assign o_rdy  = (r_cnt != 2'd2);
    assign o_vld  = (r_cnt != 2'd0) || i_vld;
    assign o_dat  = (r_cnt != 2'd0) ? r_d0 : i_dat;
    assign w_pop  = (r_cnt != 2'd0) && i_rdy;
    // Bypassed beats that leave the same cycle are never stored.
    assign w_push = i_vld && o_rdy && !((r_cnt == 2'd0) && i_rdy);

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_cnt <= 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_cnt == 2'd0) r_d0 <= i_dat;
                    else               r_d1 <= i_dat;
                    r_cnt <= r_cnt + 2'd1;
                end
                2'b01: begin
                    r_d0  <= r_d1;
                    r_cnt <= r_cnt - 2'd1;
                end
                2'b11: begin
                    if (r_cnt == 2'd1) begin
                        r_d0 <= i_dat;
                    end else begin
                        r_d0 <= r_d1;
                        r_d1 <= i_dat;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/hsv_core_alu_exec.sv
// ALU execute: S1 operand setup, S2 add/compare/bitwise/shift; optional HSV_ALU_OUT_SKID_EN skid.
// Latency: accept in cycle N -> out_valid in N+2, 1 op/cycle.
// Backpressure: valid/ready; out_ready gates advance combinationally unless the skid is built.
module hsv_core_alu_exec
    import hsv_core_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = $clog2(XLEN)
) (
    input  logic             clk_core,
    input  logic             rst_core,
    input  logic             flush_req,
    input  logic             in_valid,
    output logic             in_ready,
    input  alu_data_t        in_alu_data,
    input  logic [XLEN-1:0]  in_rs1,
    input  logic [XLEN-1:0]  in_rs2,
    input  logic [XLEN-1:0]  in_imm,
    input  logic [XLEN-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output exec_mem_common_t out_common,
    output logic             out_illegal
);

    if (XLEN != 32) begin : g_xlen_chk
        $error("hsv_core_alu_exec supports XLEN=32 only");
    end

    logic             r_s1_vld;
    alu_setup_t       r_s1;
    logic             r_s2_vld;
    word              r_s2_result;
    exec_mem_common_t r_s2_common;
    logic             r_s2_illegal;

    logic             w_s2_adv;
    logic             w_acc;
    alu_setup_t       w_setup;
    logic [32:0]      w_sum;
    word              w_b_eff;
    word              w_shin;
    word              w_shr;
    word              w_result;
    logic [SHAMT_W-1:0] w_shamt;

    assign in_ready = !r_s1_vld || w_s2_adv;
    assign w_acc    = in_valid && in_ready && !flush_req && !rst_core;

    // Flipping the sign bits turns a signed compare into an unsigned one.
    always_comb begin
        w_setup.a = in_alu_data.pc_relative ? in_pc : in_rs1;
        w_setup.b = in_alu_data.is_immediate ? in_imm : in_rs2;
        if (in_alu_data.flip_signs) begin
            w_setup.a[31] = ~w_setup.a[31];
            w_setup.b[31] = ~w_setup.b[31];
        end
        w_setup.control.out_select     = in_alu_data.out_select;
        w_setup.control.bitwise_select = in_alu_data.bitwise_select;
        w_setup.control.negate         = in_alu_data.negate;
        w_setup.control.compare        = in_alu_data.compare;
        w_setup.control.sign_extend    = in_alu_data.sign_extend;
        w_setup.common                 = in_alu_data.common;
        w_setup.illegal                = in_alu_data.illegal;
    end

    always_ff @(posedge clk_core) begin
        if (rst_core || flush_req) begin
            r_s1_vld <= 1'b0;
        end else if (in_ready) begin
            r_s1_vld <= in_valid;
        end
        if (w_acc) begin
            r_s1 <= w_setup;
        end
    end

    // Left shift reuses the right shifter through bit reversal.
    always_comb begin
        w_b_eff = r_s1.control.negate ? ~r_s1.b : r_s1.b;
        w_sum   = {1'b0, r_s1.a} + {1'b0, w_b_eff} + 33'(r_s1.control.negate);
        w_shamt = r_s1.b[SHAMT_W-1:0];
        w_shin  = r_s1.control.negate ? bit_reverse(r_s1.a) : r_s1.a;
        if (r_s1.control.sign_extend && !r_s1.control.negate) begin
            w_shr = word'($signed(w_shin) >>> w_shamt);
        end else begin
            w_shr = w_shin >> w_shamt;
        end
        w_result = '0;
        if (r_s1.control.out_select == ALU_OUT_ADDER) begin
            w_result = r_s1.control.compare ? {31'b0, ~w_sum[32]} : w_sum[31:0];
        end else begin
            case (r_s1.control.bitwise_select)
                ALU_BITWISE_AND: w_result = r_s1.a & r_s1.b;
                ALU_BITWISE_OR:  w_result = r_s1.a | r_s1.b;
                ALU_BITWISE_XOR: w_result = r_s1.a ^ r_s1.b;
                default:         w_result = r_s1.control.negate ? bit_reverse(w_shr) : w_shr;
            endcase
        end
        if (r_s1.illegal) begin
            w_result = '0;
        end
    end

    always_ff @(posedge clk_core) begin
        if (rst_core) begin
            r_s2_vld     <= 1'b0;
            r_s2_result  <= '0;
            r_s2_common  <= '0;
            r_s2_illegal <= 1'b0;
        end else begin
            if (flush_req) begin
                r_s2_vld <= 1'b0;
            end else if (w_s2_adv) begin
                r_s2_vld <= r_s1_vld;
            end
            if (w_s2_adv && r_s1_vld && !flush_req) begin
                r_s2_result  <= w_result;
                r_s2_common  <= r_s1.common;
                r_s2_illegal <= r_s1.illegal;
            end
        end
    end

`ifdef HSV_ALU_OUT_SKID_EN
    localparam int SKID_W = XLEN + $bits(exec_mem_common_t) + 1;

    logic              w_skid_rdy;
    logic [SKID_W-1:0] w_skid_dat;

    assign w_s2_adv = !r_s2_vld || w_skid_rdy;

    hsv_core_alu_skid #(
        .W(SKID_W)
    ) u_skid (
        .i_clk   (clk_core),
        .i_rst   (rst_core),
        .i_flush (flush_req),
        .i_vld   (r_s2_vld),
        .i_dat   ({r_s2_result, r_s2_common, r_s2_illegal}),
        .o_rdy   (w_skid_rdy),
        .o_vld   (out_valid),
        .o_dat   (w_skid_dat),
        .i_rdy   (out_ready)
    );

    assign {out_result, out_common, out_illegal} = w_skid_dat;
`else
    assign w_s2_adv    = !r_s2_vld || out_ready;
    assign out_valid   = r_s2_vld;
    assign out_result  = r_s2_result;
    assign out_common  = r_s2_common;
    assign out_illegal = r_s2_illegal;
`endif

endmodule

// File: tb/tb_hsv_core_alu_exec.sv
// Bench for hsv_core_alu_exec: directed literal cases plus randomized traffic against a queue model.
// Latency: n/a.
// Backpressure: out_ready stalls and flushes driven from the bench.
module tb_hsv_core_alu_exec;
    import hsv_core_pkg::*;

    logic             clk_core = 1'b0;
    logic             rst_core = 1'b1;
    logic             flush_req = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    alu_data_t        in_alu_data = '0;
    word              in_rs1 = '0;
    word              in_rs2 = '0;
    word              in_imm = '0;
    word              in_pc = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    word              out_result;
    exec_mem_common_t out_common;
    logic             out_illegal;

    int checks = 0;
    int errors = 0;
    int n_hs = 0;
    logic s_done;

    typedef struct packed {
        word              res;
        logic             ill;
        exec_mem_common_t common;
    } exp_t;

    exp_t q[$];

    hsv_core_alu_exec dut (
        .clk_core    (clk_core),
        .rst_core    (rst_core),
        .flush_req   (flush_req),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_alu_data (in_alu_data),
        .in_rs1      (in_rs1),
        .in_rs2      (in_rs2),
        .in_imm      (in_imm),
        .in_pc       (in_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_common  (out_common),
        .out_illegal (out_illegal)
    );

    always #5 clk_core = ~clk_core;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Reference: operand selection, sign flip, then plain arithmetic per operation.
    function automatic word model(alu_data_t d, word rs1, word rs2, word imm, word pc);
        word a;
        word b;
        int  sh;
        a = d.pc_relative ? pc : rs1;
        b = d.is_immediate ? imm : rs2;
        if (d.flip_signs) begin
            a = a ^ 32'h8000_0000;
            b = b ^ 32'h8000_0000;
        end
        if (d.illegal) return 32'h0;
        sh = int'(b % 32);
        if (d.out_select == ALU_OUT_ADDER) begin
            if (d.compare) return (a < b) ? 32'd1 : 32'd0;
            return d.negate ? a - b : a + b;
        end
        case (d.bitwise_select)
            ALU_BITWISE_AND: return a & b;
            ALU_BITWISE_OR:  return a | b;
            ALU_BITWISE_XOR: return a ^ b;
            default: begin
                if (d.negate)      return a << sh;
                if (d.sign_extend) return word'($signed(a) >>> sh);
                return a >> sh;
            end
        endcase
    endfunction

    function automatic alu_data_t mk(alu_out_select_t sel, alu_bitwise_t bw, logic neg, logic flip,
                                     logic cmp, logic sext, logic pcr, logic imm, logic ill);
        alu_data_t d;
        d = '0;
        d.out_select = sel;  d.bitwise_select = bw;
        d.negate = neg;      d.flip_signs = flip;  d.compare = cmp;
        d.sign_extend = sext; d.pc_relative = pcr; d.is_immediate = imm;
        d.illegal = ill;     d.common = exec_mem_common_t'(9'h0A5);
        return d;
    endfunction

    function automatic word rval();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            default: return $urandom();
        endcase
    endfunction

    task automatic gen();
        alu_data_t d;
        logic      ii;
        ii = logic'($urandom_range(0, 1));
        case ($urandom_range(0, 11))
            0:  d = mk(ALU_OUT_ADDER, ALU_BITWISE_AND,  0, 0, 0, 0, 0, ii, 0);
            1:  d = mk(ALU_OUT_ADDER, ALU_BITWISE_AND,  1, 0, 0, 0, 0, 0,  0);
            2:  d = mk(ALU_OUT_ADDER, ALU_BITWISE_AND,  1, 1, 1, 0, 0, ii, 0);
            3:  d = mk(ALU_OUT_ADDER, ALU_BITWISE_AND,  1, 0, 1, 0, 0, ii, 0);
            4:  d = mk(ALU_OUT_SHIFT, ALU_BITWISE_AND,  0, 0, 0, 0, 0, ii, 0);
            5:  d = mk(ALU_OUT_SHIFT, ALU_BITWISE_OR,   0, 0, 0, 0, 0, ii, 0);
            6:  d = mk(ALU_OUT_SHIFT, ALU_BITWISE_XOR,  0, 0, 0, 0, 0, ii, 0);
            7:  d = mk(ALU_OUT_SHIFT, ALU_BITWISE_PASS, 1, 0, 0, 0, 0, ii, 0);
            8:  d = mk(ALU_OUT_SHIFT, ALU_BITWISE_PASS, 0, 0, 0, 0, 0, ii, 0);
            9:  d = mk(ALU_OUT_SHIFT, ALU_BITWISE_PASS, 0, 0, 0, 1, 0, ii, 0);
            10: d = mk(ALU_OUT_ADDER, ALU_BITWISE_AND,  0, 0, 0, 0, 0, 1,  0);
            default: d = mk(ALU_OUT_ADDER, ALU_BITWISE_AND, 0, 0, 0, 0, 1, 1, 0);
        endcase
        d.illegal = ($urandom_range(0, 9) == 0);
        d.common  = exec_mem_common_t'($urandom_range(0, 511));
        in_alu_data = d;
        in_rs1 = rval();
        in_rs2 = rval();
        in_imm = rval();
        in_pc  = $urandom() & 32'hFFFF_FFFC;
        in_valid = 1'b1;
    endtask

    // Compare process: one model entry per accepted op, checked on every output handshake.
    logic             st_prev = 1'b0;
    logic [63:0]      st_val;
    always @(negedge clk_core) begin
        if (rst_core) begin
            q.delete();
            st_prev = 1'b0;
        end else begin
            if (st_prev) begin
                chk("stall_hold_vld", 64'(out_valid), 64'd1);
                chk("stall_hold_dat", 64'({out_result, out_illegal, out_common}), st_val);
            end
            if (out_valid) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL out_without_op actual=%h expected=none", out_result);
                end else if (out_ready) begin
                    chk("out_vs_model", 64'({out_result, out_illegal, out_common}), 64'(q.pop_front()));
                    n_hs++;
                end
            end
            if (in_valid && in_ready && !flush_req) begin
                exp_t e;
                e.res    = model(in_alu_data, in_rs1, in_rs2, in_imm, in_pc);
                e.ill    = in_alu_data.illegal;
                e.common = in_alu_data.common;
                q.push_back(e);
            end
            if (flush_req) q.delete();
            st_prev = out_valid && !out_ready && !flush_req;
            st_val  = 64'({out_result, out_illegal, out_common});
        end
    end

    task automatic run_one(input string nm, input alu_data_t d, input word rs1, input word rs2,
                           input word imm, input word pc, input word exp_res, input logic exp_ill);
        int n;
        chk({"model_", nm}, 64'(model(d, rs1, rs2, imm, pc)), 64'(exp_res));
        in_alu_data = d; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_pc = pc;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk_core); #1; n++;
        end
        if (n == 20) chk({nm, "_accept_timeout"}, 64'(in_ready), 64'd1);
        @(posedge clk_core); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 10) begin
            @(posedge clk_core); #1; n++;
        end
        chk({nm, "_latency"}, 64'(n), 64'd1);
        chk({nm, "_result"}, 64'(out_result), 64'(exp_res));
        chk({nm, "_illegal"}, 64'(out_illegal), 64'(exp_ill));
        @(posedge clk_core); #1;
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        while (q.size() != 0 && n < 50) begin
            @(posedge clk_core); #1; n++;
        end
        chk({nm, "_drained"}, 64'(q.size()), 64'd0);
    endtask

    task automatic stream(input int nops, input int mode, input int sw, input logic fl_en);
        s_done = 1'b0;
        fork
            begin
                int  i;
                int  cyc;
                logic cons;
                i = 0;
                cyc = 0;
                while (i < nops && cyc < 3000) begin
                    if (!in_valid && (mode == 0 || $urandom_range(0, 3) != 0)) gen();
                    @(negedge clk_core);
                    cons = in_valid && in_ready;
                    @(posedge clk_core); #1;
                    cyc++;
                    if (cons) begin
                        in_valid = 1'b0;
                        i++;
                    end
                end
                if (i < nops) chk("stream_issue_timeout", 64'(i), 64'(nops));
                in_valid = 1'b0;
                s_done = 1'b1;
            end
            begin
                int c;
                c = 0;
                while (!s_done) begin
                    out_ready = (mode == 0) ? !(c >= sw && c < sw + 3) : ($urandom_range(0, 9) < 7);
                    flush_req = fl_en && ($urandom_range(0, 39) == 0);
                    @(posedge clk_core); #1;
                    c++;
                end
                out_ready = 1'b1;
                flush_req = 1'b0;
            end
        join
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int h0;
        repeat (3) @(posedge clk_core);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_result", 64'(out_result), 64'd0);
        chk("rst_out_illegal", 64'(out_illegal), 64'd0);
        rst_core = 1'b0;
        @(posedge clk_core); #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_idle_valid", 64'(out_valid), 64'd0);

        run_one("add",   mk(ALU_OUT_ADDER, ALU_BITWISE_AND, 0, 0, 0, 0, 0, 0, 0), 5, 7, 0, 0, 32'd12, 0);
        run_one("slt",   mk(ALU_OUT_ADDER, ALU_BITWISE_AND, 1, 1, 1, 0, 0, 0, 0), 32'hFFFF_FFFF, 1, 0, 0, 32'd1, 0);
        run_one("sltu",  mk(ALU_OUT_ADDER, ALU_BITWISE_AND, 1, 0, 1, 0, 0, 0, 0), 32'hFFFF_FFFF, 1, 0, 0, 32'd0, 0);
        run_one("sub",   mk(ALU_OUT_ADDER, ALU_BITWISE_AND, 1, 0, 0, 0, 0, 0, 0), 3, 5, 0, 0, 32'hFFFF_FFFE, 0);
        run_one("sll",   mk(ALU_OUT_SHIFT, ALU_BITWISE_PASS, 1, 0, 0, 0, 0, 0, 0), 1, 31, 0, 0, 32'h8000_0000, 0);
        run_one("sra",   mk(ALU_OUT_SHIFT, ALU_BITWISE_PASS, 0, 0, 0, 1, 0, 0, 0), 32'h8000_0000, 4, 0, 0, 32'hF800_0000, 0);
        run_one("srl",   mk(ALU_OUT_SHIFT, ALU_BITWISE_PASS, 0, 0, 0, 0, 0, 0, 0), 32'h8000_0000, 4, 0, 0, 32'h0800_0000, 0);
        run_one("sh0",   mk(ALU_OUT_SHIFT, ALU_BITWISE_PASS, 1, 0, 0, 0, 0, 0, 0), 32'h1234_5678, 32, 0, 0, 32'h1234_5678, 0);
        run_one("auipc", mk(ALU_OUT_ADDER, ALU_BITWISE_AND, 0, 0, 0, 0, 1, 1, 0), 0, 0, 32'h2000, 32'h1000, 32'h3000, 0);
        run_one("ill",   mk(ALU_OUT_ADDER, ALU_BITWISE_AND, 0, 0, 0, 0, 0, 0, 1), 5, 7, 0, 0, 32'd0, 1);

        // Eight back-to-back ops with a 3-cycle out_ready stall in the middle.
        h0 = n_hs;
        stream(8, 0, 3, 1'b0);
        drain("b2b");
        chk("b2b_count", 64'(n_hs - h0), 64'd8);

        // Flush with one op in S2, one in S1, and a new op offered in the flush cycle.
        out_ready = 1'b0;
        gen(); in_alu_data.illegal = 1'b0;
        @(posedge clk_core); #1;
        gen(); in_alu_data.illegal = 1'b0;
        @(posedge clk_core); #1;
        gen(); in_alu_data.illegal = 1'b0;
        flush_req = 1'b1;
        @(posedge clk_core); #1;
        flush_req = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("flush_no_out", 64'(out_valid), 64'd0);
            @(posedge clk_core); #1;
        end
        run_one("post_flush", mk(ALU_OUT_SHIFT, ALU_BITWISE_XOR, 0, 0, 0, 0, 0, 1, 0), 32'hF0F0_0000, 0, 32'h0FF0_00FF, 0, 32'hFF00_00FF, 0);

        // Reset while an op is in flight.
        gen();
        @(posedge clk_core); #1;
        in_valid = 1'b0;
        rst_core = 1'b1;
        @(posedge clk_core); #1;
        rst_core = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("rst_mid_no_out", 64'(out_valid), 64'd0);
            @(posedge clk_core); #1;
        end

        stream(300, 1, 0, 1'b0);
        drain("rand");
        stream(300, 1, 0, 1'b1);
        drain("rand_flush");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
